rx_dac_out_stage: RTL and testbench



---
 rtl/rx_dac_out_stage.sv | 207 ++++++++++++++++++++
 tb/tb_rx_dac_out_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_dac_out_stage.sv
// DAC output stage: per-DAC mute/unmute gain ramp and a two-stage scaling pipeline.
// Define RX_DAC_ROUND_EN to round half-up before the >>>8; otherwise the result is truncated.
module rx_dac_out_stage #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int NUMBER_OF_DAC  = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int RAMP_STEP      = 1
) (
    input  logic                                              clock,
    input  logic                                              resetn,
    input  logic [DATA_WIDTH*NUMBER_OF_LINE*NUMBER_OF_DAC-1:0] in_data,
    input  logic                                              in_valid,
    input  logic [NUMBER_OF_DAC-1:0]                          dac_enable,
    output logic [DATA_WIDTH*NUMBER_OF_LINE*NUMBER_OF_DAC-1:0] dac_data,
    output logic                                              dac_valid,
    output logic [NUMBER_OF_DAC-1:0]                          dac_active,
    output logic [NUMBER_OF_DAC-1:0]                          dac_muted
);

    localparam int         NUM_LANES  = NUMBER_OF_LINE * NUMBER_OF_DAC;
    localparam int         PROD_W     = DATA_WIDTH + 10;
    localparam logic [8:0] GAIN_UNITY = 9'd256;
    localparam logic [9:0] STEP_W     = 10'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_MUTED     = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    function automatic logic [8:0] gain_up(input logic [8:0] g);
        logic [9:0] w_sum;
        w_sum = {1'b0, g} + STEP_W;
        if (w_sum > {1'b0, GAIN_UNITY}) begin
            return GAIN_UNITY;
        end else begin
            return w_sum[8:0];
        end
    endfunction

    function automatic logic [8:0] gain_down(input logic [8:0] g);
        logic [9:0] w_diff;
        w_diff = {1'b0, g} - STEP_W;
        if (STEP_W >= {1'b0, g}) begin
            return 9'd0;
        end else begin
            return w_diff[8:0];
        end
    endfunction

    state_t                   r_state     [NUMBER_OF_DAC];
    state_t                   w_state_nxt [NUMBER_OF_DAC];
    logic [8:0]               r_gain      [NUMBER_OF_DAC];
    logic [8:0]               w_gain_nxt  [NUMBER_OF_DAC];
    logic [8:0]               w_gain_up   [NUMBER_OF_DAC];
    logic [8:0]               w_gain_dn   [NUMBER_OF_DAC];
    logic [NUMBER_OF_DAC-1:0] w_active_nxt;
    logic [NUMBER_OF_DAC-1:0] w_muted_nxt;

    logic [PROD_W-1:0] w_prod [NUM_LANES];
    logic [PROD_W-1:0] r_prod [NUM_LANES];
    logic              r_valid1;
    logic [DATA_WIDTH*NUM_LANES-1:0] w_scaled;

    // Saturating gain candidates for both ramp directions
    always_comb begin
        for (int d = 0; d < NUMBER_OF_DAC; d++) begin
            w_gain_up[d] = gain_up(r_gain[d]);
            w_gain_dn[d] = gain_down(r_gain[d]);
        end
    end

    // FSM state register; state and gain only move on valid cycles
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int d = 0; d < NUMBER_OF_DAC; d++) begin
                r_state[d] <= ST_MUTED;
                r_gain[d]  <= 9'd0;
            end
        end else if (in_valid) begin
            for (int d = 0; d < NUMBER_OF_DAC; d++) begin
                r_state[d] <= w_state_nxt[d];
                r_gain[d]  <= w_gain_nxt[d];
            end
        end
    end

    // FSM next-state logic; a step landing on a rail finishes the ramp immediately
    always_comb begin
        for (int d = 0; d < NUMBER_OF_DAC; d++) begin
            w_state_nxt[d] = r_state[d];
            case (r_state[d])
                ST_MUTED: begin
                    if (dac_enable[d]) begin
                        w_state_nxt[d] = (w_gain_up[d] == GAIN_UNITY) ? ST_ACTIVE : ST_RAMP_UP;
                    end else begin
                        w_state_nxt[d] = ST_MUTED;
                    end
                end
                ST_RAMP_UP: begin
                    if (!dac_enable[d]) begin
                        w_state_nxt[d] = ST_RAMP_DOWN;
                    end else if (w_gain_up[d] == GAIN_UNITY) begin
                        w_state_nxt[d] = ST_ACTIVE;
                    end else begin
                        w_state_nxt[d] = ST_RAMP_UP;
                    end
                end
                ST_ACTIVE: begin
                    if (!dac_enable[d]) begin
                        w_state_nxt[d] = (w_gain_dn[d] == 9'd0) ? ST_MUTED : ST_RAMP_DOWN;
                    end else begin
                        w_state_nxt[d] = ST_ACTIVE;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (dac_enable[d]) begin
                        w_state_nxt[d] = ST_RAMP_UP;
                    end else if (w_gain_dn[d] == 9'd0) begin
                        w_state_nxt[d] = ST_MUTED;
                    end else begin
                        w_state_nxt[d] = ST_RAMP_DOWN;
                    end
                end
                default: w_state_nxt[d] = ST_MUTED;
            endcase
        end
    end

    // FSM outputs: next gain (held on a direction reversal) and status decodes
    always_comb begin
        for (int d = 0; d < NUMBER_OF_DAC; d++) begin
            w_gain_nxt[d]   = r_gain[d];
            w_active_nxt[d] = (w_state_nxt[d] == ST_ACTIVE);
            w_muted_nxt[d]  = (w_state_nxt[d] == ST_MUTED);
            case (r_state[d])
                ST_MUTED:     w_gain_nxt[d] = dac_enable[d] ? w_gain_up[d] : 9'd0;
                ST_RAMP_UP:   w_gain_nxt[d] = dac_enable[d] ? w_gain_up[d] : r_gain[d];
                ST_ACTIVE:    w_gain_nxt[d] = dac_enable[d] ? GAIN_UNITY : w_gain_dn[d];
                ST_RAMP_DOWN: w_gain_nxt[d] = dac_enable[d] ? r_gain[d] : w_gain_dn[d];
                default:      w_gain_nxt[d] = 9'd0;
            endcase
        end
    end

    // Registered status flags, updated together with the state they decode
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dac_active <= '0;
            dac_muted  <= '1;
        end else if (in_valid) begin
            dac_active <= w_active_nxt;
            dac_muted  <= w_muted_nxt;
        end
    end

    // Per-lane multiply and shift; gain is zero-extended so it multiplies as a positive value
    for (genvar gd = 0; gd < NUMBER_OF_DAC; gd++) begin : g_dac
        for (genvar gl = 0; gl < NUMBER_OF_LINE; gl++) begin : g_lane
            localparam int IDX = gd * NUMBER_OF_LINE + gl;
            logic [DATA_WIDTH-1:0] w_sample;
            logic [PROD_W-1:0]     w_round;
            logic                  w_lane_unused;

            assign w_sample    = in_data[DATA_WIDTH*IDX +: DATA_WIDTH];
            assign w_prod[IDX] = {{10{w_sample[DATA_WIDTH-1]}}, w_sample}
                               * {{(DATA_WIDTH+1){1'b0}}, r_gain[gd]};
`ifdef RX_DAC_ROUND_EN
            assign w_round = r_prod[IDX] + {{(PROD_W-8){1'b0}}, 8'h80};
`else
            assign w_round = r_prod[IDX];
`endif
            assign w_scaled[DATA_WIDTH*IDX +: DATA_WIDTH] = w_round[DATA_WIDTH+7:8];
            assign w_lane_unused = ^{w_round[PROD_W-1:DATA_WIDTH+8], w_round[7:0]};
        end
    end

    // Stage 1: register products and the valid qualifier every cycle
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_valid1 <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_valid1 <= in_valid;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_prod[i] <= w_prod[i];
            end
        end
    end

    // Stage 2: scaled output updates only for valid samples, holds across gaps
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dac_data  <= '0;
            dac_valid <= 1'b0;
        end else begin
            dac_valid <= r_valid1;
            if (r_valid1) begin
                dac_data <= w_scaled;
            end
        end
    end

endmodule

// File: tb/tb_rx_dac_out_stage.sv
// Directed bench for rx_dac_out_stage: default 3x8x16 instance plus a 4x2x14 instance.
module tb_rx_dac_out_stage;

    localparam int W  = 16 * 8 * 3;
    localparam int PW = 14 * 2 * 4;

    logic          clock = 1'b0;
    logic          resetn;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic [2:0]    dac_enable;
    logic [W-1:0]  dac_data;
    logic          dac_valid;
    logic [2:0]    dac_active;
    logic [2:0]    dac_muted;

    logic          p_resetn;
    logic [PW-1:0] p_in_data;
    logic          p_in_valid;
    logic [3:0]    p_dac_enable;
    logic [PW-1:0] p_dac_data;
    logic          p_dac_valid;
    logic [3:0]    p_dac_active;
    logic [3:0]    p_dac_muted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    rx_dac_out_stage #(
        .NUMBER_OF_LINE(8), .NUMBER_OF_DAC(3), .DATA_WIDTH(16), .RAMP_STEP(1)
    ) u_dut (
        .clock(clock), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .dac_enable(dac_enable), .dac_data(dac_data), .dac_valid(dac_valid),
        .dac_active(dac_active), .dac_muted(dac_muted)
    );

    rx_dac_out_stage #(
        .NUMBER_OF_LINE(2), .NUMBER_OF_DAC(4), .DATA_WIDTH(14), .RAMP_STEP(64)
    ) u_dut_p (
        .clock(clock), .resetn(p_resetn), .in_data(p_in_data), .in_valid(p_in_valid),
        .dac_enable(p_dac_enable), .dac_data(p_dac_data), .dac_valid(p_dac_valid),
        .dac_active(p_dac_active), .dac_muted(p_dac_muted)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] fill_dac(input int d, input logic [15:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < 8; l++) r[16*(d*8+l) +: 16] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] fill_all(input logic [15:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 24; i++) r[16*i +: 16] = v;
        return r;
    endfunction

    // gain used by sample k in the reversal scenario (disable applied at sample 129)
    function automatic int rev_gain(input int k);
        if (k <= 0) return 0;
        else if (k <= 129) return k - 1;
        else if (258 - k > 0) return 258 - k;
        else return 0;
    endfunction

    task automatic do_reset();
        resetn = 1'b0; in_valid = 1'b0; dac_enable = 3'b000; in_data = '0;
        tick(); tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; dac_enable = 3'b111; in_valid = 1'b1; in_data = fill_all(16'h4000);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (dac_data !== '0 || dac_valid !== 1'b0 || dac_muted !== 3'b111 || dac_active !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d valid=%b muted=%b active=%b data=%h, required 0/111/000/0",
                         i, dac_valid, dac_muted, dac_active, dac_data);
            end
        end
        resetn = 1'b1;
        tick();
        n_tests++;
        if (dac_data !== '0 || dac_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_out valid=%b data=%h, required valid=0 data=0", dac_valid, dac_data);
        end
        tick();
        n_tests++;
        if (dac_data !== '0 || dac_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_second_out valid=%b data=%h, required valid=1 data=0", dac_valid, dac_data);
        end
    endtask

    task automatic test_full_ramp();
        int g;
        logic [W-1:0] exp;
        do_reset();
        in_data = fill_all(16'h4000); dac_enable = 3'b001; in_valid = 1'b1;
        for (int t = 1; t <= 262; t++) begin
            tick();
            g = (t < 2) ? 0 : ((t - 2 > 256) ? 256 : t - 2);
            exp = fill_dac(0, 16'(64 * g));
            n_tests++;
            if (dac_data !== exp || dac_valid !== (t >= 2)) begin
                n_fail++;
                $display("FAIL full_ramp t=%0d valid=%b lane0=%h, required lane0=%h", t, dac_valid,
                         dac_data[15:0], exp[15:0]);
            end
            if (t == 255) begin
                n_tests++;
                if (dac_active !== 3'b000) begin
                    n_fail++;
                    $display("FAIL ramp_active_early active=%b, required 000", dac_active);
                end
            end
            if (t == 258) begin
                n_tests++;
                if (dac_active !== 3'b001 || dac_muted !== 3'b110) begin
                    n_fail++;
                    $display("FAIL ramp_active active=%b muted=%b, required 001/110", dac_active, dac_muted);
                end
            end
        end
    endtask

    task automatic test_reversal();
        logic [W-1:0] exp;
        do_reset();
        in_data = fill_all(16'h4000); dac_enable = 3'b001; in_valid = 1'b1;
        for (int t = 1; t <= 262; t++) begin
            if (t == 129) dac_enable = 3'b000;
            tick();
            exp = fill_dac(0, 16'(64 * rev_gain(t - 1)));
            n_tests++;
            if (dac_data !== exp) begin
                n_fail++;
                $display("FAIL reversal t=%0d lane0=%h dac1_lane0=%h, required %h", t,
                         dac_data[15:0], dac_data[143:128], exp[15:0]);
            end
        end
        n_tests++;
        if (dac_muted !== 3'b111 || dac_active !== 3'b000) begin
            n_fail++;
            $display("FAIL reversal_muted muted=%b active=%b, required 111/000", dac_muted, dac_active);
        end
    endtask

    task automatic test_valid_gaps();
        logic        v_hist [0:40];
        logic [15:0] eo [0:40];
        int nv;
        do_reset();
        in_data = fill_all(16'h4000); dac_enable = 3'b001;
        v_hist[0] = 1'b0; eo[0] = 16'h0000; nv = 0;
        for (int t = 1; t <= 40; t++) begin
            in_valid = (t % 3 != 0);
            v_hist[t] = in_valid;
            if (in_valid) begin
                eo[t] = 16'(64 * nv);
                nv++;
            end else begin
                eo[t] = eo[t-1];
            end
            tick();
            n_tests++;
            if (dac_valid !== v_hist[t-1] || dac_data !== fill_dac(0, eo[t-1])) begin
                n_fail++;
                $display("FAIL valid_gaps t=%0d valid=%b lane0=%h, required valid=%b lane0=%h", t,
                         dac_valid, dac_data[15:0], v_hist[t-1], eo[t-1]);
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        resetn = 1'b0; in_valid = 1'b1; dac_enable = 3'b001; in_data = fill_all(16'h4000);
        tick();
        resetn = 1'b1;
        tick();
        n_tests++;
        if (dac_data !== '0 || dac_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_out1 valid=%b lane0=%h, required 0/0000", dac_valid, dac_data[15:0]);
        end
        tick();
        n_tests++;
        if (dac_data !== '0 || dac_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_out2 valid=%b lane0=%h, required 1/0000", dac_valid, dac_data[15:0]);
        end
        tick();
        n_tests++;
        if (dac_data !== fill_dac(0, 16'h0040)) begin
            n_fail++;
            $display("FAIL midreset_out3 lane0=%h, required 0040", dac_data[15:0]);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] exp_round;
`ifdef RX_DAC_ROUND_EN
        exp_round = 16'h0001;
`else
        exp_round = 16'h0000;
`endif
        do_reset();
        dac_enable = 3'b001; in_valid = 1'b1; in_data = '0;
        tick();
        dac_enable = 3'b000; in_data = fill_all(16'h0080);
        tick();
        in_data = fill_all(16'hC000);
        tick();
        n_tests++;
        if (dac_data !== fill_dac(0, exp_round)) begin
            n_fail++;
            $display("FAIL round_0080 lane0=%h dac1_lane0=%h, required %h/0000", dac_data[15:0],
                     dac_data[143:128], exp_round);
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (dac_data !== fill_dac(0, 16'hFFC0) || dac_muted !== 3'b111) begin
            n_fail++;
            $display("FAIL round_c000 lane0=%h muted=%b, required ffc0/111", dac_data[15:0], dac_muted);
        end
    endtask

    task automatic test_param();
        logic [PW-1:0] pvec [0:3];
        logic [PW-1:0] exp;
        logic [13:0]   lv;
        p_resetn = 1'b0; p_in_valid = 1'b0; p_dac_enable = 4'h0; p_in_data = '0;
        tick(); tick();
        p_resetn = 1'b1; p_dac_enable = 4'hF; p_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_tests++;
        if (p_dac_active !== 4'hF || p_dac_muted !== 4'h0) begin
            n_fail++;
            $display("FAIL param_active active=%b muted=%b, required 1111/0000", p_dac_active, p_dac_muted);
        end
        for (int k = 0; k < 4; k++) begin
            pvec[k] = '0;
            for (int i = 0; i < 8; i++) begin
                lv = (k == 3) ? ((i % 2 == 1) ? 14'h1FFF : 14'h2000) : 14'(k * 2011 + i * 313 + 1);
                pvec[k][14*i +: 14] = lv;
            end
        end
        for (int t = 0; t <= 5; t++) begin
            p_in_valid = (t < 4);
            p_in_data  = (t < 4) ? pvec[t] : '0;
            tick();
            exp = (t == 0) ? '0 : ((t <= 4) ? pvec[t-1] : pvec[3]);
            n_tests++;
            if (p_dac_valid !== (t <= 4)) begin
                n_fail++;
                $display("FAIL param_valid t=%0d valid=%b, required %b", t, p_dac_valid, (t <= 4));
            end
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (p_dac_data[14*i +: 14] !== exp[14*i +: 14]) begin
                    n_fail++;
                    $display("FAIL param_lane t=%0d idx=%0d got=%h, required %h", t, i,
                             p_dac_data[14*i +: 14], exp[14*i +: 14]);
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; dac_enable = 3'b000; in_data = '0;
        p_resetn = 1'b0; p_in_valid = 1'b0; p_dac_enable = 4'h0; p_in_data = '0;
        test_reset();
        test_full_ramp();
        test_reversal();
        test_valid_gaps();
        test_reset_mid_ramp();
        test_rounding();
        test_param();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
